// File: rtl/kros_pkg.sv
// Shared constants for the KROS light-show datapath: default bus widths,
// play-mode encodings and the step FSM state type.
package kros_pkg;

  localparam int unsigned SEQ_W  = 6;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned NUM_CH = 10;
  localparam int unsigned FREQ_W = 3;

  localparam logic [1:0] MODE_FWD  = 2'd0;
  localparam logic [1:0] MODE_REV  = 2'd1;
  localparam logic [1:0] MODE_PING = 2'd2;
  localparam logic [1:0] MODE_ONE  = 2'd3;

  // Walk direction / completion of the step walker.
  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DN   = 2'd1,
    ST_DONE = 2'd2
  } step_state_e;

endpackage

// File: rtl/pb_edge.sv
// Pushbutton conditioner: 2-FF synchroniser followed by a rising-edge detect.
// Ports:
//   clk, rst  - clock, async active-high reset
//   pb        - raw asynchronous button level
//   pulse_c   - one-cycle pulse on each synchronised rising edge (combinational)
module pb_edge (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pulse_c
);

  logic s1, s2, s2_d;

  // Synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= pb;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign pulse_c = s2 & ~s2_d;

endmodule

// File: rtl/step_sequencer.sv
// Multi-mode pattern sequencer: internal step tick from freq_num, pattern
// select by pushbuttons, forward/reverse/ping-pong/one-shot step walk and a
// registered LED bus fed from the pattern ROM.
// Ports:
//   CLK_50, reset         - clock, async active-high reset
//   pb_seq_up, pb_seq_dn  - raw buttons: next / previous pattern
//   freq_num              - speed select (larger = faster)
//   mode                  - 0 fwd, 1 rev, 2 ping-pong, 3 one-shot
//   run                   - 1 advance, 0 pause
//   rom_data              - pattern ROM data (1-cycle read latency)
//   rom_addr              - {seq_num, step_num}
//   seq_num, step_num     - current pattern / step
//   LEDR                  - registered ROM data
//   done                  - one-shot pattern complete
module step_sequencer #(
  parameter int unsigned SEQ_W    = kros_pkg::SEQ_W,
  parameter int unsigned STEP_W   = kros_pkg::STEP_W,
  parameter int unsigned NUM_CH   = kros_pkg::NUM_CH,
  parameter int unsigned FREQ_W   = kros_pkg::FREQ_W,
  parameter int unsigned BASE_DIV = 390625,
  parameter int unsigned DIV_W    = 26
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic                    pb_seq_up,
  input  logic                    pb_seq_dn,
  input  logic [FREQ_W-1:0]       freq_num,
  input  logic [1:0]              mode,
  input  logic                    run,
  input  logic [NUM_CH-1:0]       rom_data,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [STEP_W-1:0]       step_num,
  output logic [NUM_CH-1:0]       LEDR,
  output logic                    done
);

  import kros_pkg::*;

  localparam logic [STEP_W-1:0] STEP_MAX  = '1;
  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  logic              up_c, dn_c, seq_chg_c, tick_c, done_d;
  logic [DIV_W-1:0]  period_c, div_q, div_d;
  logic [SEQ_W-1:0]  seq_d;
  logic [STEP_W-1:0] step_d;
  step_state_e       state_q, state_d, state_eff;

  pb_edge u_pb_up (.clk(CLK_50), .rst(reset), .pb(pb_seq_up), .pulse_c(up_c));
  pb_edge u_pb_dn (.clk(CLK_50), .rst(reset), .pb(pb_seq_dn), .pulse_c(dn_c));

  // Simultaneous up and down requests cancel.
  assign seq_chg_c = up_c ^ dn_c;

  // Period doubles for each step below the top speed; the >= compare lets a
  // shorter period take effect without waiting for the old one to expire.
  assign period_c = DIV_W'(BASE_DIV) << (~freq_num);
  assign tick_c   = run && (div_q >= (period_c - DIV_W'(1)));

  assign rom_addr = {seq_num, step_num};

  // Next-state logic for pattern counter, divider and step walker.
  always_comb begin
    // Drop flags left over from a mode that is no longer selected.
    state_eff = state_q;
    if ((mode != MODE_PING) && (state_eff == ST_DN))   state_eff = ST_UP;
    if ((mode != MODE_ONE)  && (state_eff == ST_DONE)) state_eff = ST_UP;

    state_d = state_eff;
    seq_d   = seq_num;
    step_d  = step_num;
    div_d   = div_q;

    if (seq_chg_c) begin
      seq_d   = up_c ? (seq_num + SEQ_W'(1)) : (seq_num - SEQ_W'(1));
      step_d  = (mode == MODE_REV) ? STEP_MAX : STEP_ZERO;
      div_d   = '0;
      state_d = ST_UP;
    end else if (run) begin
      if (!tick_c) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        case (mode)
          MODE_FWD: step_d = step_num + STEP_ONE;
          MODE_REV: step_d = step_num - STEP_ONE;
          MODE_PING: begin
            // Flip on arriving at an endpoint so each endpoint plays once.
            if (state_eff == ST_UP) begin
              if (step_num == STEP_MAX) begin
                step_d  = STEP_MAX - STEP_ONE;
                state_d = ST_DN;
              end else begin
                step_d = step_num + STEP_ONE;
                if (step_num == (STEP_MAX - STEP_ONE)) state_d = ST_DN;
              end
            end else begin
              if (step_num == STEP_ZERO) begin
                step_d  = STEP_ONE;
                state_d = ST_UP;
              end else begin
                step_d = step_num - STEP_ONE;
                if (step_num == STEP_ONE) state_d = ST_UP;
              end
            end
          end
          MODE_ONE: begin
            if (state_eff != ST_DONE) begin
              if (step_num == STEP_MAX) state_d = ST_DONE;
              else                      step_d  = step_num + STEP_ONE;
            end
          end
          default: ;
        endcase
      end
    end

    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_UP;
      seq_num  <= '0;
      step_num <= '0;
      div_q    <= '0;
      done     <= 1'b0;
      LEDR     <= '0;
    end else begin
      state_q  <= state_d;
      seq_num  <= seq_d;
      step_num <= step_d;
      div_q    <= div_d;
      done     <= done_d;
      LEDR     <= rom_data;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_up = 1'b0, pb_dn = 1'b0;
  logic [2:0] freq = 3'd7;
  logic [1:0] mode = 2'd0;
  logic       run = 1'b0;
  logic [9:0] rom_data;
  logic [9:0] rom_addr;
  logic [5:0] seq_num;
  logic [3:0] step_num;
  logic [9:0] ledr;
  logic       done;

  int nchk = 0;
  int nerr = 0;

  // Behavioural model state.
  int m_seq, m_step, m_done, m_dir, m_cnt, rom_exp, led_exp;
  bit [2:0] hu, hd;

  step_sequencer #(.BASE_DIV(2)) dut (
    .CLK_50(clk), .reset(rst), .pb_seq_up(pb_up), .pb_seq_dn(pb_dn),
    .freq_num(freq), .mode(mode), .run(run), .rom_data(rom_data),
    .rom_addr(rom_addr), .seq_num(seq_num), .step_num(step_num),
    .LEDR(ledr), .done(done)
  );

  always #5 clk = ~clk;

  // Pattern ROM: data equals address, one cycle of read latency.
  always_ff @(posedge clk) rom_data <= rom_addr;

  typedef struct {
    logic [1:0] mode;
    logic       run;
    logic [2:0] freq;
    logic       up;
    logic       dn;
    int         n;
    int         seq;
    int         step;
    int         done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seq = 0; m_step = 0; m_done = 0; m_dir = 1; m_cnt = 0;
    rom_exp = 0; led_exp = 0; hu = '0; hd = '0;
  endtask

  task automatic model_advance();
    case (int'(mode))
      0: m_step = (m_step + 1) % 16;
      1: m_step = (m_step + 15) % 16;
      2: begin
        if (m_step + m_dir > 15 || m_step + m_dir < 0) m_dir = -m_dir;
        m_step = m_step + m_dir;
        if (m_step == 15) m_dir = -1;
        if (m_step == 0)  m_dir = 1;
      end
      default: begin
        if (m_done == 0) begin
          if (m_step == 15) m_done = 1;
          else m_step = m_step + 1;
        end
      end
    endcase
  endtask

  // One clock edge of the reference model, from the written rules.
  task automatic model_update();
    bit pu, pd, tk;
    int p;
    if (rst) begin
      model_reset();
      return;
    end
    pu = hu[1] & ~hu[2];
    pd = hd[1] & ~hd[2];
    hu = {hu[1:0], pb_up};
    hd = {hd[1:0], pb_dn};
    led_exp = rom_exp;
    rom_exp = m_seq * 16 + m_step;
    p  = 2 << (7 - int'(freq));
    tk = run && (m_cnt >= p - 1);
    if (pu != pd) begin
      m_seq  = pu ? (m_seq + 1) % 64 : (m_seq + 63) % 64;
      m_step = (mode == 2'd1) ? 15 : 0;
      m_cnt  = 0; m_done = 0; m_dir = 1;
    end else if (run) begin
      if (tk) begin
        m_cnt = 0;
        model_advance();
      end else begin
        m_cnt++;
      end
    end
    if (mode != 2'd2) m_dir = 1;
    if (mode != 2'd3) m_done = 0;
  endtask

  task automatic step1();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step1();
    step1();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " seq"}, int'(seq_num), 0);
    chk({tag, " step"}, int'(step_num), 0);
    chk({tag, " addr"}, int'(rom_addr), 0);
    chk({tag, " led"}, int'(ledr), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " seq"}, int'(seq_num), m_seq);
    chk({tag, " step"}, int'(step_num), m_step);
    chk({tag, " done"}, int'(done), m_done);
    chk({tag, " addr"}, int'(rom_addr), m_seq * 16 + m_step);
    chk({tag, " led"}, int'(ledr), led_exp);
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(49, 0) == 0) run = ~run;
      if ($urandom_range(59, 0) == 0) freq = 3'($urandom_range(7, 5));
      if ($urandom_range(24, 0) == 0) pb_up = ~pb_up;
      if ($urandom_range(24, 0) == 0) pb_dn = ~pb_dn;
      step1();
      chk_model("rand");
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    chk_zero("reset");

    // mode, run, freq, up, dn, cycles, seq, step, done
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 20, 0, 0, 0});
    vecs.push_back('{2'd0, 1'b1, 3'd7, 1'b0, 1'b0, 10, 0, 5, 0});
    vecs.push_back('{2'd0, 1'b1, 3'd7, 1'b0, 1'b0, 21, 0, 15, 0});
    vecs.push_back('{2'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1, 0, 0, 0});
    vecs.push_back('{2'd0, 1'b1, 3'd6, 1'b0, 1'b0, 8, 0, 2, 0});
    vecs.push_back('{2'd1, 1'b1, 3'd7, 1'b0, 1'b0, 6, 0, 15, 0});
    vecs.push_back('{2'd3, 1'b1, 3'd7, 1'b0, 1'b0, 2, 0, 15, 1});
    vecs.push_back('{2'd3, 1'b1, 3'd7, 1'b0, 1'b0, 20, 0, 15, 1});
    vecs.push_back('{2'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1, 0, 15, 0});
    vecs.push_back('{2'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1, 0, 0, 0});
    vecs.push_back('{2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 30, 0, 15, 0});
    vecs.push_back('{2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 2, 0, 14, 0});
    vecs.push_back('{2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 28, 0, 0, 0});
    vecs.push_back('{2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 2, 0, 1, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b0, 1'b1, 3, 63, 0, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 4, 63, 0, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b1, 1'b0, 50, 0, 0, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 4, 0, 0, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b1, 1'b1, 10, 0, 0, 0});
    vecs.push_back('{2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 4, 0, 0, 0});
    vecs.push_back('{2'd1, 1'b0, 3'd7, 1'b1, 1'b0, 3, 1, 15, 0});
    vecs.push_back('{2'd1, 1'b0, 3'd7, 1'b0, 1'b0, 4, 1, 15, 0});
    vecs.push_back('{2'd3, 1'b1, 3'd7, 1'b0, 1'b0, 2, 1, 15, 1});

    foreach (vecs[i]) begin
      mode = vecs[i].mode; run = vecs[i].run; freq = vecs[i].freq;
      pb_up = vecs[i].up; pb_dn = vecs[i].dn;
      for (int c = 0; c < vecs[i].n; c++) step1();
      chk($sformatf("vec%0d seq", i), int'(seq_num), vecs[i].seq);
      chk($sformatf("vec%0d step", i), int'(step_num), vecs[i].step);
      chk($sformatf("vec%0d done", i), int'(done), vecs[i].done);
    end

    // Button pulse lands on the same edge as a tick: pattern change wins.
    mode = 2'd0; run = 1'b0; freq = 3'd7; pb_up = 1'b0; pb_dn = 1'b0;
    do_reset();
    run = 1'b1;
    step1();
    pb_up = 1'b1;
    step1();
    step1();
    chk("coll before seq", int'(seq_num), 0);
    chk("coll before step", int'(step_num), 1);
    step1();
    chk("coll seq", int'(seq_num), 1);
    chk("coll step", int'(step_num), 0);
    step1();
    step1();
    chk("coll after step", int'(step_num), 1);
    pb_up = 1'b0;

    // ROM path: reach address 0x2A5 and watch LEDR follow two cycles later.
    run = 1'b0;
    do_reset();
    for (int k = 0; k < 42; k++) begin
      pb_up = 1'b1;
      repeat (3) step1();
      pb_up = 1'b0;
      repeat (3) step1();
    end
    chk("rom seq", int'(seq_num), 42);
    run = 1'b1;
    repeat (10) step1();
    run = 1'b0;
    chk("rom addr", int'(rom_addr), 10'h2A5);
    step1();
    chk("rom led +1", int'(ledr), 10'h2A4);
    step1();
    chk("rom led +2", int'(ledr), 10'h2A5);

    // Randomized run against the model, with an async reset mid-cycle.
    do_reset();
    run = 1'b1;
    rand_cycles(1500);
    #2 rst = 1'b1;
    #1 chk_zero("async");
    step1();
    rst = 1'b0;
    rand_cycles(1500);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
